sort_stream_tx: RTL and testbench

SORT_STREAM_TX -- requirements
Module: sort_stream_tx

---
 rtl/sort_stream_tx.sv | 92 +++++++++
 tb/tb_sort_stream_tx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_stream_tx.sv
// Streams a captured sorter result array out over a valid/ready interface,
// one element per cycle, flagging frames that are not non-decreasing.
module sort_stream_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          load,
  input  logic [(1<<ADDR_WIDTH)-1:0][DATA_WIDTH-1:0]    sorted_array,
  input  logic [ADDR_WIDTH:0]                           count,
  output logic [DATA_WIDTH-1:0]                         out_data,
  output logic [ADDR_WIDTH-1:0]                         out_index,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic                                          out_last,
  output logic                                          busy,
  output logic                                          done,
  output logic                                          order_err
);
  localparam int unsigned       DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, SEND, FINISH} state_t;

  state_t                              state, state_next;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]    mem;
  logic [ADDR_WIDTH:0]                 cnt, cnt_eff;
  logic [ADDR_WIDTH-1:0]               idx;
  logic                                capture, xfer, at_last, unsorted;

  assign capture = (state == IDLE) && load;
  assign xfer    = (state == SEND) && out_ready;
  assign cnt_eff = (count > DEPTH_CNT) ? DEPTH_CNT : count;
  assign at_last = ({1'b0, idx} == (cnt - (ADDR_WIDTH+1)'(1)));

  // Only adjacent pairs inside the effective count participate in the check.
  always_comb begin
    unsorted = 1'b0;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      if (((ADDR_WIDTH+1)'(i) < cnt_eff) &&
          (sorted_array[ADDR_WIDTH'(i)] < sorted_array[ADDR_WIDTH'(i-1)]))
        unsorted = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load) state_next = (cnt_eff != '0) ? SEND : FINISH;
      SEND:    if (out_ready && at_last) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == SEND);
    busy      = (state != IDLE);
    done      = (state == FINISH);
    out_data  = '0;
    out_index = '0;
    out_last  = 1'b0;
    if (state == SEND) begin
      out_data  = mem[idx];
      out_index = idx;
      out_last  = at_last;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem       <= '0;
      cnt       <= '0;
      idx       <= '0;
      order_err <= 1'b0;
    end else if (capture) begin
      mem       <= sorted_array;
      cnt       <= cnt_eff;
      idx       <= '0;
      order_err <= unsorted;
    end else if (xfer) begin
      idx <= idx + ADDR_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_sort_stream_tx.sv
// Scoreboard bench for sort_stream_tx: stimulus pushes expected beats,
// a negedge monitor pops and compares on every transfer.
module tb_sort_stream_tx;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int N  = 1 << AW;

  typedef logic [N-1:0][DW-1:0] arr_t;
  typedef struct packed {
    logic [DW-1:0] d;
    logic [AW-1:0] i;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset, load, out_ready;
  arr_t          sorted_array;
  logic [AW:0]   count;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_index;
  logic          out_valid, out_last, busy, done, order_err;

  int    checks = 0;
  int    errors = 0;
  int    done_seen = 0;
  int    exp_done = 0;
  int    ready_mode = 0;
  beat_t exp_q[$];

  sort_stream_tx #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .load(load), .sorted_array(sorted_array),
    .count(count), .out_data(out_data), .out_index(out_index),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done), .order_err(order_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
    end
  endtask

  // Monitor: transfer compare, stall stability, zero-when-idle, done counting.
  beat_t prev;
  bit    stalled = 1'b0;
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (done) done_seen++;
      if (stalled) begin
        chk("stall_valid", {31'b0, out_valid}, 32'd1);
        chk("stall_hold", {out_data, out_index, out_last}, prev);
      end
      if (!out_valid)
        chk("idle_zero", {out_data, out_index, out_last}, 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual=data %0h index %0d required=no beat", out_data, out_index);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_data", {24'b0, out_data}, {24'b0, e.d});
          chk("beat_index", {28'b0, out_index}, {28'b0, e.i});
          chk("beat_last", {31'b0, out_last}, {31'b0, e.l});
        end
      end
      stalled = out_valid && !out_ready;
      prev    = {out_data, out_index, out_last};
    end else begin
      stalled = 1'b0;
    end
  end

  // Ready driver: mode 0 holds ready high, mode 1 repeats 1,0,0.
  initial begin
    int p;
    p = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = (ready_mode == 0) ? 1'b1 : ((p % 3) == 0);
      p++;
    end
  end

  task automatic do_load(input arr_t arr, input int cnt);
    int eff;
    beat_t b;
    eff = (cnt > N) ? N : cnt;
    @(posedge clk);
    #1;
    sorted_array = arr;
    count        = cnt[AW:0];
    load         = 1'b1;
    for (int i = 0; i < eff; i++) begin
      b.d = arr[i];
      b.i = AW'(i);
      b.l = (i == eff - 1);
      exp_q.push_back(b);
    end
    exp_done++;
    @(posedge clk);
    #1;
    load = 1'b0;
    sorted_array = ~arr;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < budget);
    chk("idle_timeout", {31'b0, busy}, 32'd0);
  endtask

  task automatic wait_beat(input int k);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(out_valid && out_index == AW'(k)) && n < 50);
    chk("reach_beat", {27'b0, out_valid, out_index}, {27'b0, 1'b1, 4'(k)});
  endtask

  function automatic arr_t ramp(input int start, input int step);
    arr_t a;
    for (int i = 0; i < N; i++) a[i] = DW'(start + i * step);
    return a;
  endfunction

  initial begin
    arr_t a;
    int   unsorted_vals[8];
    unsorted_vals = '{5, 3, 8, 6, 2, 4, 7, 1};
    reset = 1'b0;
    load = 1'b0;
    count = '0;
    sorted_array = '0;
    #2;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_order_err", {31'b0, order_err}, 32'd0);
    chk("rst_outs", {out_data, out_index, out_last}, 32'd0);
    #20;
    reset = 1'b1;

    // 1..8 at full throughput
    do_load(ramp(1, 1), 8);
    chk("latency_valid", {31'b0, out_valid}, 32'd1);
    chk("busy_send", {31'b0, busy}, 32'd1);
    chk("sorted_err", {31'b0, order_err}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("full_tput", {31'b0, out_valid}, 32'd1);
    end
    @(negedge clk);
    chk("finish_done", {30'b0, done, out_valid}, 32'd2);
    chk("finish_busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    chk("done_one_cycle", {30'b0, done, busy}, 32'd0);

    // Same frame with back-pressure
    ready_mode = 1;
    do_load(ramp(1, 1), 8);
    wait_idle(100);
    ready_mode = 0;

    // Unsorted frame streamed in buffer order
    a = '0;
    for (int i = 0; i < 8; i++) a[i] = DW'(unsorted_vals[i]);
    do_load(a, 8);
    chk("unsorted_err", {31'b0, order_err}, 32'd1);
    wait_idle(50);
    chk("err_holds", {31'b0, order_err}, 32'd1);

    // count = 0: no beats, done on the cycle after load
    do_load(ramp(9, 1), 0);
    chk("cnt0_err", {31'b0, order_err}, 32'd0);
    @(negedge clk);
    chk("cnt0_novalid", {31'b0, out_valid}, 32'd0);
    chk("cnt0_done", {31'b0, done}, 32'd1);
    @(negedge clk);
    chk("cnt0_idle", {30'b0, done, busy}, 32'd0);

    // count = 20 clamps to 16 beats
    do_load(ramp(0, 3), 20);
    wait_idle(50);
    chk("cnt20_err", {31'b0, order_err}, 32'd0);

    // Descent beyond the count is not an ordering error
    a = ramp(1, 1);
    a[3] = 8'd0;
    do_load(a, 3);
    chk("cnt3_err", {31'b0, order_err}, 32'd0);
    wait_idle(50);

    // Load during beat 3 is ignored
    do_load(ramp(10, 1), 8);
    wait_beat(2);
    sorted_array = ramp(200, -7);
    count = 5'd5;
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    wait_idle(50);
    chk("ignored_load_err", {31'b0, order_err}, 32'd0);

    // Reset during beat 5 abandons the frame
    do_load(ramp(20, 1), 8);
    wait_beat(4);
    #1;
    reset = 1'b0;
    exp_q.delete();
    exp_done--;
    #1;
    chk("midrst_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_outs", {out_data, out_index, out_last}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    do_load(ramp(30, 1), 8);
    wait_idle(50);

    repeat (2) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    chk("done_count", done_seen, exp_done);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
